// File: rtl/midas_disp_pkg.sv
// Shared types and constants for the byte display scheduler.
//   byte_t               : one displayable byte
//   disp_state_e         : scheduler FSM states
//   DEFAULT_DWELL_CYCLES : clocks per source at 50 MHz (1 s)
package midas_disp_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    PINNED = 2'd2
  } disp_state_e;

  localparam int DEFAULT_DWELL_CYCLES = 50_000_000;

endpackage

// File: rtl/mod_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requesting index found when scanning from i_start
// upward and wrapping modulo N_SRC.
//   i_req   : per-source request vector
//   i_start : first index to examine (must be < N_SRC)
//   o_idx   : selected index (0 when nothing is found)
//   o_found : 1 when at least one request is set
module mod_rr_pick #(
  parameter  int N_SRC = 4,
  localparam int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // start < N_SRC and k < N_SRC, so a single conditional subtract wraps.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] s, input int k);
    int c;
    c = int'(s) + k;
    if (c >= N_SRC) c = c - N_SRC;
    return IDX_W'(c);
  endfunction

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!o_found && i_req[wrap_add(i_start, k)]) begin
        o_idx   = wrap_add(i_start, k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_byte_display_sched.sv
// Time-shares a two-digit byte display among N_SRC byte producers.
// Rotates round-robin over requesting sources, DWELL_CYCLES clocks each,
// with a pin override that locks the display onto one source.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req        : per-source request (level)
//   i_values     : flattened source bytes, source k at [8k+7:8k]
//   i_pin_en     : pin override enable
//   i_pin_idx    : source to pin (ignored when >= N_SRC)
//   o_value      : byte to display (registered)
//   o_src_idx    : index of the source shown (registered)
//   o_blank      : 1 while idle, display shows nothing
//   o_switch     : one-cycle pulse when the shown source changes
//   o_state      : current FSM state, for observation
module mod_byte_display_sched
  import midas_disp_pkg::*;
#(
  parameter  int N_SRC        = 4,
  parameter  int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  localparam int IDX_W        = $clog2(N_SRC),
  localparam int CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_SRC-1:0]     i_req,
  input  logic [N_SRC*8-1:0]   i_values,
  input  logic                 i_pin_en,
  input  logic [IDX_W-1:0]     i_pin_idx,
  output byte_t                o_value,
  output logic [IDX_W-1:0]     o_src_idx,
  output logic                 o_blank,
  output logic                 o_switch,
  output disp_state_e          o_state
);

  localparam logic [IDX_W:0]   N_SRC_W   = N_SRC[IDX_W:0];
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SRC - 1);

  disp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  byte_t            value_q, value_d;
  logic             switch_q, switch_d;

  logic             pin_valid;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] pick_ptr_idx, pick_next_idx;
  logic             pick_ptr_found, pick_next_found;

  // Widened compare so the check stays meaningful for non-power-of-2 N_SRC.
  assign pin_valid = i_pin_en && ({1'b0, i_pin_idx} < N_SRC_W);
  assign idx_inc   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // Resume point when leaving IDLE.
  mod_rr_pick #(.N_SRC(N_SRC)) u_pick_ptr (
    .i_req   (i_req),
    .i_start (ptr_q),
    .o_idx   (pick_ptr_idx),
    .o_found (pick_ptr_found)
  );

  // Successor of the current source, for drop, expiry and pin release.
  mod_rr_pick #(.N_SRC(N_SRC)) u_pick_next (
    .i_req   (i_req),
    .i_start (idx_inc),
    .o_idx   (pick_next_idx),
    .o_found (pick_next_found)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      value_q  <= 8'h00;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      value_q  <= value_d;
      switch_q <= switch_d;
    end
  end

  // Next-state logic: pin > current-source drop > dwell expiry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pin_valid) begin
          state_d = PINNED;
          idx_d   = i_pin_idx;
        end else if (pick_ptr_found) begin
          state_d = SHOW;
          idx_d   = pick_ptr_idx;
        end
      end
      SHOW: begin
        if (pin_valid) begin
          state_d = PINNED;
          idx_d   = i_pin_idx;
          cnt_d   = '0;
        end else if (!i_req[idx_q]) begin
          cnt_d = '0;
          if (pick_next_found) idx_d = pick_next_idx;
          else                 state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // i_req[idx_q] is set, so the scan always finds something;
          // a sole requester wraps back onto itself.
          idx_d = pick_next_idx;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PINNED: begin
        cnt_d = '0;
        if (pin_valid) begin
          idx_d = i_pin_idx;
        end else if (i_req[idx_q]) begin
          state_d = SHOW;
        end else if (pick_next_found) begin
          state_d = SHOW;
          idx_d   = pick_next_idx;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    ptr_d = (state_d != IDLE) ? idx_d : ptr_q;
  end

  // Output logic: value tracks the next source live; held while idle.
  always_comb begin
    value_d  = value_q;
    switch_d = 1'b0;
    if (state_d != IDLE) begin
      value_d  = i_values[{idx_d, 3'b000} +: 8];
      switch_d = (idx_d != idx_q) || (state_q == IDLE);
    end
  end

  assign o_value   = value_q;
  assign o_src_idx = idx_q;
  assign o_blank   = (state_q == IDLE);
  assign o_switch  = switch_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_mod_byte_display_sched.sv
// Directed bench for mod_byte_display_sched: a 4-source instance for most
// scenarios and a 5-source instance for the out-of-range pin index case.
module tb_mod_byte_display_sched;
  import midas_disp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-source instance
  logic [3:0]  req     = '0;
  logic [31:0] values  = '0;
  logic        pin_en  = 1'b0;
  logic [1:0]  pin_idx = '0;
  byte_t       value;
  logic [1:0]  src_idx;
  logic        blank, sw;
  disp_state_e state;

  // 5-source instance
  logic [4:0]  req5     = '0;
  logic [39:0] values5  = '0;
  logic        pin_en5  = 1'b0;
  logic [2:0]  pin_idx5 = '0;
  byte_t       value5;
  logic [2:0]  src_idx5;
  logic        blank5, sw5;
  disp_state_e state5;

  int n_vec = 0;
  int n_err = 0;

  mod_byte_display_sched #(.N_SRC(4), .DWELL_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_values(values),
    .i_pin_en(pin_en), .i_pin_idx(pin_idx),
    .o_value(value), .o_src_idx(src_idx), .o_blank(blank),
    .o_switch(sw), .o_state(state)
  );

  mod_byte_display_sched #(.N_SRC(5), .DWELL_CYCLES(4)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_req(req5), .i_values(values5),
    .i_pin_en(pin_en5), .i_pin_idx(pin_idx5),
    .o_value(value5), .o_src_idx(src_idx5), .o_blank(blank5),
    .o_switch(sw5), .o_state(state5)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [7:0] b);
    values[8*k +: 8] = b;
  endtask

  task automatic set_src5(input int k, input logic [7:0] b);
    values5[8*k +: 8] = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0; pin_en = 1'b0; pin_idx = '0; values = '0;
    req5 = '0; pin_en5 = 1'b0; pin_idx5 = '0; values5 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = 4'($urandom); values = $urandom; pin_en = 1'($urandom); pin_idx = 2'($urandom);
    req5 = 5'($urandom); values5 = {8'($urandom), $urandom}; pin_en5 = 1'($urandom);
    pin_idx5 = 3'($urandom);
    tick();
    tick();
    if (blank !== 1'b1) begin $display("FAIL reset_blank got=%b exp=1", blank); n_err++; end
    n_vec++;
    if (value !== 8'h00) begin $display("FAIL reset_value got=%h exp=00", value); n_err++; end
    n_vec++;
    if (src_idx !== 2'd0) begin $display("FAIL reset_idx got=%0d exp=0", src_idx); n_err++; end
    n_vec++;
    if (sw !== 1'b0) begin $display("FAIL reset_switch got=%b exp=0", sw); n_err++; end
    n_vec++;
    if (state !== IDLE) begin $display("FAIL reset_state got=%0d exp=%0d", state, IDLE); n_err++; end
    n_vec++;
    if ({blank5, value5, src_idx5, sw5} !== {1'b1, 8'h00, 3'd0, 1'b0}) begin
      $display("FAIL reset_n5 got=%b/%h/%0d/%b exp=1/00/0/0", blank5, value5, src_idx5, sw5);
      n_err++;
    end
    n_vec++;
    rst = 1'b0;
    req = '0; pin_en = 1'b0; req5 = '0; pin_en5 = 1'b0;
  endtask

  task automatic test_rotation();
    apply_reset();
    req = 4'b0101; set_src(0, 8'h12); set_src(2, 8'hAB);
    tick();
    if ({src_idx, value, sw, blank} !== {2'd0, 8'h12, 1'b1, 1'b0}) begin
      $display("FAIL rot_enter got=%0d/%h/%b/%b exp=0/12/1/0", src_idx, value, sw, blank);
      n_err++;
    end
    n_vec++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({src_idx, sw} !== {2'd0, 1'b0}) begin
        $display("FAIL rot_dwell0 cyc=%0d got=%0d/%b exp=0/0", i, src_idx, sw);
        n_err++;
      end
      n_vec++;
    end
    tick();
    if ({src_idx, value, sw} !== {2'd2, 8'hAB, 1'b1}) begin
      $display("FAIL rot_to2 got=%0d/%h/%b exp=2/ab/1", src_idx, value, sw);
      n_err++;
    end
    n_vec++;
    for (int i = 0; i < 3; i++) tick();
    if ({src_idx, sw} !== {2'd2, 1'b0}) begin
      $display("FAIL rot_dwell2 got=%0d/%b exp=2/0", src_idx, sw);
      n_err++;
    end
    n_vec++;
    tick();
    if ({src_idx, value, sw} !== {2'd0, 8'h12, 1'b1}) begin
      $display("FAIL rot_back0 got=%0d/%h/%b exp=0/12/1", src_idx, value, sw);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_sole_requester();
    apply_reset();
    req = 4'b0010; set_src(1, 8'h5C);
    tick();
    if ({src_idx, value, sw} !== {2'd1, 8'h5C, 1'b1}) begin
      $display("FAIL sole_enter got=%0d/%h/%b exp=1/5c/1", src_idx, value, sw);
      n_err++;
    end
    n_vec++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({src_idx, sw, blank} !== {2'd1, 1'b0, 1'b0}) begin
        $display("FAIL sole_hold cyc=%0d got=%0d/%b/%b exp=1/0/0", i, src_idx, sw, blank);
        n_err++;
      end
      n_vec++;
    end
    set_src(1, 8'h5D);
    tick();
    if ({src_idx, value} !== {2'd1, 8'h5D}) begin
      $display("FAIL sole_live got=%0d/%h exp=1/5d", src_idx, value);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_request_drop();
    apply_reset();
    req = 4'b0011; set_src(0, 8'h11); set_src(1, 8'h22);
    tick();
    tick();
    req = 4'b0010;
    tick();
    if ({src_idx, value, sw} !== {2'd1, 8'h22, 1'b1}) begin
      $display("FAIL drop_switch got=%0d/%h/%b exp=1/22/1", src_idx, value, sw);
      n_err++;
    end
    n_vec++;
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (src_idx !== 2'd1) begin
        $display("FAIL drop_hold cyc=%0d got=%0d exp=1", i, src_idx);
        n_err++;
      end
      n_vec++;
    end
    tick();
    if ({src_idx, value, sw} !== {2'd0, 8'h11, 1'b1}) begin
      $display("FAIL drop_rotate got=%0d/%h/%b exp=0/11/1", src_idx, value, sw);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_pin();
    apply_reset();
    req = 4'b0000; pin_en = 1'b1; pin_idx = 2'd3; set_src(3, 8'hF0);
    tick();
    if ({state, blank, value, src_idx, sw} !== {PINNED, 1'b0, 8'hF0, 2'd3, 1'b1}) begin
      $display("FAIL pin_enter got=%0d/%b/%h/%0d/%b exp=2/0/f0/3/1", state, blank, value, src_idx, sw);
      n_err++;
    end
    n_vec++;
    for (int i = 0; i < 6; i++) tick();
    if ({state, blank, src_idx, sw} !== {PINNED, 1'b0, 2'd3, 1'b0}) begin
      $display("FAIL pin_hold got=%0d/%b/%0d/%b exp=2/0/3/0", state, blank, src_idx, sw);
      n_err++;
    end
    n_vec++;
    pin_idx = 2'd1; set_src(1, 8'h77);
    tick();
    if ({src_idx, value, sw} !== {2'd1, 8'h77, 1'b1}) begin
      $display("FAIL pin_follow got=%0d/%h/%b exp=1/77/1", src_idx, value, sw);
      n_err++;
    end
    n_vec++;
    pin_en = 1'b0;
    tick();
    if ({state, blank, value, sw} !== {IDLE, 1'b1, 8'h77, 1'b0}) begin
      $display("FAIL pin_release got=%0d/%b/%h/%b exp=0/1/77/0", state, blank, value, sw);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_pin_invalid_n5();
    apply_reset();
    req5 = 5'b00001; set_src5(0, 8'h3C); set_src5(4, 8'hC4);
    pin_en5 = 1'b1; pin_idx5 = 3'd7;
    tick();
    if ({state5, src_idx5, value5, sw5} !== {SHOW, 3'd0, 8'h3C, 1'b1}) begin
      $display("FAIL n5_badpin got=%0d/%0d/%h/%b exp=1/0/3c/1", state5, src_idx5, value5, sw5);
      n_err++;
    end
    n_vec++;
    for (int i = 0; i < 5; i++) tick();
    if ({state5, src_idx5} !== {SHOW, 3'd0}) begin
      $display("FAIL n5_badpin_hold got=%0d/%0d exp=1/0", state5, src_idx5);
      n_err++;
    end
    n_vec++;
    pin_idx5 = 3'd4;
    tick();
    if ({state5, src_idx5, value5, sw5} !== {PINNED, 3'd4, 8'hC4, 1'b1}) begin
      $display("FAIL n5_pin4 got=%0d/%0d/%h/%b exp=2/4/c4/1", state5, src_idx5, value5, sw5);
      n_err++;
    end
    n_vec++;
    pin_idx5 = 3'd5;
    tick();
    if ({state5, src_idx5, value5, sw5} !== {SHOW, 3'd0, 8'h3C, 1'b1}) begin
      $display("FAIL n5_release_wrap got=%0d/%0d/%h/%b exp=1/0/3c/1", state5, src_idx5, value5, sw5);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0101; set_src(0, 8'h12); set_src(2, 8'hAB);
    for (int i = 0; i < 5; i++) tick();
    if (src_idx !== 2'd2) begin
      $display("FAIL mid_pre got=%0d exp=2", src_idx);
      n_err++;
    end
    n_vec++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    if ({state, blank, value, src_idx, sw} !== {IDLE, 1'b1, 8'h00, 2'd0, 1'b0}) begin
      $display("FAIL mid_reset got=%0d/%b/%h/%0d/%b exp=0/1/00/0/0", state, blank, value, src_idx, sw);
      n_err++;
    end
    n_vec++;
    rst = 1'b0;
    tick();
    if ({state, src_idx, value, sw} !== {SHOW, 2'd0, 8'h12, 1'b1}) begin
      $display("FAIL mid_restart got=%0d/%0d/%h/%b exp=1/0/12/1", state, src_idx, value, sw);
      n_err++;
    end
    n_vec++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rotation();
    test_sole_requester();
    test_request_drop();
    test_pin();
    test_pin_invalid_n5();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
